// File: rtl/prefix_add_sequencer_pkg.sv
// Shared constants and state encoding for the sliced add/sub sequencer.
package prefix_add_sequencer_pkg;

    localparam int INPUTSIZE = 16;
    localparam int GROUPSIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The slice index must be at least one bit wide, even when there is a single slice.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/prefix_add_sequencer_if.sv
// Request, result and shared-adder signals of the sequencer. The master side is the EXU
// together with the external combinational adder; the slave side is the sequencer.
interface prefix_add_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [CHUNK-1:0] add_a;
    logic [CHUNK-1:0] add_b;
    logic             add_cin;
    logic [CHUNK-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready, add_sum, add_cout,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready, add_sum, add_cout,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/prefix_add_sequencer_slice_mux.sv
// Selects the current operand slices for the shared adder and decodes the result-slice
// write enable. Everything is zero while inactive so the adder sees quiet inputs.
module seq_slice_mux #(
    parameter int WIDTH  = 64,
    parameter int CHUNK  = 16,
    parameter int NCHUNK = WIDTH / CHUNK,
    parameter int IDX_W  = 2
) (
    input  logic              active,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b_eff,
    output logic [CHUNK-1:0]  slice_a,
    output logic [CHUNK-1:0]  slice_b,
    output logic [NCHUNK-1:0] wr_en
);

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        slice_a = '0;
        slice_b = '0;
        wr_en   = '0;
        if (active) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (idx == IDX_W'(k)) begin
                    slice_a  = a[k*CHUNK +: CHUNK];
                    slice_b  = b_eff[k*CHUNK +: CHUNK];
                    wr_en[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prefix_add_sequencer.sv
// Sequences a WIDTH-bit add/sub through one external CHUNK-bit adder, LSB slice first,
// with the carry registered between slices.
module prefix_add_sequencer
    import prefix_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = INPUTSIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prefix_add_sequencer_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam int GROUPS = CHUNK / GROUPSIZE;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("prefix_add_sequencer: WIDTH must be a multiple of CHUNK");
    end
    if (GROUPS < 2 || (GROUPS & (GROUPS - 1)) != 0) begin : g_bad_chunk
        $error("prefix_add_sequencer: CHUNK/GROUPSIZE must be a power of two >= 2");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic               out_cout_q, out_ovf_q;
    logic [NCHUNK-1:0]  wr_en;
    logic               running, accept, last;

    seq_slice_mux #(
        .WIDTH  (WIDTH),
        .CHUNK  (CHUNK),
        .NCHUNK (NCHUNK),
        .IDX_W  (IDX_W)
    ) u_slice_mux (
        .active  (running),
        .idx     (idx_q),
        .a       (a_q),
        .b_eff   (b_q),
        .slice_a (bus.add_a),
        .slice_b (bus.add_b),
        .wr_en   (wr_en)
    );

    assign running = (state_q == ST_RUN);
    assign accept  = bus.in_valid && (state_q == ST_IDLE);
    assign last    = (idx_q == IDX_W'(NCHUNK - 1));

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.add_cin   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.add_cin = carry_q;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: operand registers are reset along with the datapath so nothing depends on power-up values.
    always_ff @(posedge clk) begin
        // NOTE: all state updates are non-blocking so every register samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.in_a;
                b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                carry_q <= bus.in_sub;
                idx_q   <= '0;
            end else if (running) begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (wr_en[k]) out_sum_q[k*CHUNK +: CHUNK] <= bus.add_sum;
                end
                carry_q <= bus.add_cout;
                // The index holds on the last slice rather than wrapping.
                if (last) begin
                    out_cout_q <= bus.add_cout;
                    out_ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (bus.add_sum[CHUNK-1] != a_q[WIDTH-1]);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign bus.out_sum  = out_sum_q;
    assign bus.out_cout = out_cout_q;
    assign bus.out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_prefix_add_sequencer.sv
// Self-checking bench: spec vectors, backpressure, mid-run reset and randomized ops
// checked against whole-word arithmetic.
module tb_prefix_add_sequencer;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int MAX_WAIT = 20;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prefix_add_sequencer_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    prefix_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared adder model: a plain 16-bit add with carry.
    always_comb {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                      output logic [63:0] s, output logic c, output logic o);
        logic [63:0] bb;
        logic [64:0] t;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + 65'(sub);
        s  = t[63:0];
        c  = t[64];
        o  = (a[63] == bb[63]) && (s[63] != a[63]);
    endfunction

    // Returns at the falling edge just after the accept edge, with the inputs scrambled.
    task automatic start_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic sub);
        int w = 0;
        while (!bus.in_ready && w < MAX_WAIT) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("%s in_ready", name), 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = {$urandom, $urandom};
        bus.in_b     = {$urandom, $urandom};
        bus.in_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic [63:0] es, input logic ec, input logic eo);
        int lat;
        start_op(name, a, b, sub);
        wait_result(lat);
        check($sformatf("%s latency", name), 64'(lat), 64'(NCHUNK));
        check($sformatf("%s sum", name), bus.out_sum, es);
        check($sformatf("%s cout", name), 64'(bus.out_cout), 64'(ec));
        check($sformatf("%s ovf", name), 64'(bus.out_ovf), 64'(eo));
        check($sformatf("%s in_ready in DONE", name), 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check($sformatf("%s back to idle", name), {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] es, ra, rb;
        logic        ec, eo, rs;
        int          lat;

        vecs[0] = '{"add_ffff_1",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"add_ones_1",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0,                   1'b1, 1'b0};
        vecs[2] = '{"add_max_1",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"sub_min_1",   64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{"add_5_3",     64'd5,                   64'd3, 1'b0, 64'd8,                   1'b0, 1'b0};
        vecs[5] = '{"sub_3_5",     64'd3,                   64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_sum", bus.out_sum, 64'd0);
        check("reset flags", {62'd0, bus.out_cout, bus.out_ovf}, 64'd0);
        check("reset adder quiet", {31'd0, bus.add_cin, bus.add_a, bus.add_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Backpressure: result and flags must hold while out_ready is low.
        bus.out_ready = 1'b0;
        ra = 64'h0123_4567_89AB_CDEF;
        rb = 64'hFEDC_BA98_7654_3210;
        ref_model(ra, rb, 1'b1, es, ec, eo);
        start_op("bp", ra, rb, 1'b1);
        wait_result(lat);
        check("bp latency", 64'(lat), 64'(NCHUNK));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold %0d sum", i), bus.out_sum, es);
            check($sformatf("bp hold %0d ctl", i),
                  {59'd0, bus.out_valid, bus.in_ready, bus.busy, bus.out_cout, bus.out_ovf},
                  {59'd0, 1'b1, 1'b0, 1'b1, ec, eo});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);

        // Reset after two RUN cycles discards the operation.
        start_op("rst_mid", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid busy/valid", {62'd0, bus.busy, bus.out_valid}, 64'd0);
        check("rst_mid out_sum", bus.out_sum, 64'd0);
        check("rst_mid flags", {62'd0, bus.out_cout, bus.out_ovf}, 64'd0);
        check("rst_mid in_ready", 64'(bus.in_ready), 64'd1);
        run_op("after_rst", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0);

        // Randomized operands, biased toward carry/overflow corners.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = {ra[63], {63{ra[62]}}};
            if ($urandom_range(0, 3) == 0) rb = {rb[63], {63{rb[62]}}};
            rs = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rs, es, ec, eo);
            run_op($sformatf("rand%0d", i), ra, rb, rs, es, ec, eo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
